// File: rtl/bc_serializer_pkg.sv
// Types and helpers shared between the bc buffer and the bc serializer.
package bc_pkg;

    localparam int BC_WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_t;

    function automatic logic even_parity(input logic [BC_WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bc_serializer_if.sv
// Ready/valid word channel from the buffer read port into the serializer.
interface bc_serializer_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_rdy);
    modport slave  (input in_valid, input in_data, output in_rdy);
endinterface

// File: rtl/bc_serializer_baud_gen.sv
// Baud counter: free-runs while a frame is active and flags the last clk of each serial bit.
module bc_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);
endmodule

// File: rtl/bc_serializer.sv
// Word-to-UART-frame serializer: start bit, LSB-first data, optional even parity, stop bit(s).
module bc_serializer
    import bc_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    bc_serializer_if.slave  in_if,
    output logic            tx_out,
    output logic            busy,
    output logic            frame_done
);
    localparam int BIT_CNT_W = $clog2(DATA_W + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("bc_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("bc_serializer: STOP_BITS must be 1 or 2");
    end

    ser_state_t            state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  handshake_s, bit_tick_s, restart_s;
    logic                  last_data_s, last_stop_s;

    assign in_if.in_rdy = (state_q == IDLE) && rst;
    assign handshake_s  = in_if.in_valid && in_if.in_rdy;
    assign last_data_s  = (bit_cnt_q == BIT_CNT_W'(DATA_W - 1));
    assign last_stop_s  = (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1));
    // Baud counter is parked at zero while idle and realigned on every state change.
    assign restart_s    = (state_d != state_q) || (state_q == IDLE);

    bc_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart_s),
        .bit_tick (bit_tick_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = handshake_s ? START : IDLE;
            START:   state_d = bit_tick_s ? DATA : START;
            DATA: begin
                if (bit_tick_s && last_data_s) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY:  state_d = bit_tick_s ? STOP : PARITY;
            STOP:    state_d = (bit_tick_s && last_stop_s) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // datapath and output next values, derived from the upcoming state so tx_out lines up with it
    always_comb begin
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
        busy_d    = (state_d != IDLE);
        if (handshake_s) begin
            shift_d  = in_if.in_data;
            parity_d = even_parity(in_if.in_data);
        end else if (state_q == DATA && bit_tick_s) begin
            shift_d = shift_q >> 1;
        end else begin
            shift_d = shift_q;
        end
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (bit_tick_s && (state_q == DATA || state_q == STOP)) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign frame_done = (state_q == STOP) && bit_tick_s && last_stop_s;
endmodule
